regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with per-register busy scoreboard, successor to the single-write/dual-read core register file. Provides NUM_RD combinational read ports and NUM_WR posedge write ports, a hardwired zero register, and fixed write-port priority. Tracks outstanding writes through issue/writeback busy bits so the decode stage of each core can stall on RAW hazards. Sits between decode (reads, issue) and writeback (writes) in every core of the multicore system.

## Interface

- XLEN, 32: register data width in bits
- DEPTH, 32: number of registers; power of two, ≥ 2
- NUM_RD, 2: read ports, 1..4
- NUM_WR, 1: write ports, 1..2
- RESET_TO_INDEX, 1: 1 = register i resets to value i; 0 = all registers reset to 0
- AW (localparam): $clog2(DEPTH)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- raddr  in  NUM_RD*AW  read addresses, port p at [p*AW +: AW]
- rdata  out  NUM_RD*XLEN  read data, port p at [p*XLEN +: XLEN]
- rbusy  out  NUM_RD  busy bit of the register addressed by port p
- reg_wr  in  NUM_WR  write enable per write port
- waddr  in  NUM_WR*AW  write addresses
- wdata  in  NUM_WR*XLEN  write data
- issue_en  in  1  mark issue_addr busy (instruction with destination issued)
- issue_addr  in  AW  destination register being issued
- busy_cnt  out  AW+1  number of registers currently busy

## Operation

- Register 0: always reads 0, never written, never busy; writes and issues to address 0 are ignored.
- Write: on rising edge, for each port w with reg_wr[w]=1 and waddr≠0, register waddr takes wdata. Two ports same address same cycle: higher port index wins.
- Read: rdata[p] = register[raddr[p]] combinationally; rbusy[p] = busy[raddr[p]].
- Scoreboard: busy[issue_addr] sets on issue_en. Any accepted write to address a clears busy[a]. Same address issued and written in one cycle: set wins (new producer outstanding).
- Issue to an already-busy register: busy stays 1 (no nesting count).
- busy_cnt = popcount of busy bits, registered, updated the same edge as busy.
- Out-of-range behaviour: none possible (DEPTH power of two).

## Timing

- Write latency: data visible on rdata the cycle after the write edge (without bypass).
- Issue latency: rbusy and busy_cnt reflect issue_en the cycle after the edge.
- Reset (synchronous, checked first each edge): registers ← index or 0 per RESET_TO_INDEX; all busy ← 0; busy_cnt ← 0. Reset mid-operation discards pending writes and issues of that cycle. Register 0 is 0 in both reset modes.
- Outputs during reset: rdata follows the reset contents from the edge after reset is sampled; rbusy = 0.

## Configuration

- REGFILE_BYPASS_EN defined: write-to-read forwarding. If reg_wr[w]=1, waddr[w]≠0 and waddr[w]=raddr[p], rdata[p]=wdata[w] in the same cycle (highest-priority matching port) and rbusy[p]=0 unless issue_en targets the same address that cycle. Gives same-cycle write/read visibility without a negedge write.
- Undefined: no forwarding; same-cycle read returns the old value and old busy bit.

## Structure

- Package regfile_pkg: default XLEN/DEPTH constants, reset-mode encoding, function for write-port priority select.
- Sub-module regfile_scoreboard: busy vector, issue/clear arbitration, busy_cnt register. Data array and read muxing stay in regfile_mp.

## Test plan

- Reset with RESET_TO_INDEX=1 -> raddr=5 reads 5, raddr=0 reads 0, busy_cnt=0; RESET_TO_INDEX=0 -> raddr=5 reads 0.
- Write port 0 addr 3 data 0xDEADBEEF -> next cycle raddr=3 reads 0xDEADBEEF; write addr 0 data 0x1234 -> addr 0 still reads 0.
- NUM_WR=2, both write addr 7 (0x11 port0, 0x22 port1) -> addr 7 reads 0x22.
- issue_en addr 9 -> next cycle rbusy=1, busy_cnt=1; write addr 9 -> busy clears, busy_cnt=0; same-cycle issue+write addr 9 -> stays busy, data updated.
- With REGFILE_BYPASS_EN: write addr 4 data 0xA5 while raddr=4 -> rdata=0xA5 same cycle, rbusy=0; without macro -> old value that cycle, 0xA5 next.
- Reset asserted while reg_wr and issue_en active -> write and issue discarded, all busy 0, contents at reset values.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, reset-mode encoding and write-port priority helper for regfile_mp.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_DEPTH = 32;
  localparam int MAX_WR    = 2;

  typedef enum logic {
    RST_ZERO  = 1'b0,
    RST_INDEX = 1'b1
  } rst_mode_e;

  // Highest-index asserted hit wins; returns 0 when nothing hits.
  function automatic int wr_prio_sel(input logic [MAX_WR-1:0] hit);
    int sel;
    sel = 0;
    for (int w = 0; w < MAX_WR; w++) begin
      sel = hit[w] ? w : sel;
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue sets, accepted writes clear, issue beats clear on the
// same register; busy_cnt_o is the registered popcount of the busy vector.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_en_i,
  input  logic [AW-1:0]    issue_addr_i,
  input  logic [DEPTH-1:0] clr_i,
  output logic [DEPTH-1:0] busy_o,
  output logic [AW:0]      busy_cnt_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;

  // Next busy vector and its population count
  always_comb begin
    busy_d = '0;
    cnt_d  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0) begin
        busy_d[i] = 1'b0;
      end else if (issue_en_i && (issue_addr_i == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (clr_i[i]) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  // Busy state and count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired zero register and busy scoreboard.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN           = DEF_XLEN,
  parameter  int DEPTH          = DEF_DEPTH,
  parameter  int NUM_RD         = 2,
  parameter  int NUM_WR         = 1,
  parameter  int RESET_TO_INDEX = 1,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   raddr,
  output logic [NUM_RD*XLEN-1:0] rdata,
  output logic [NUM_RD-1:0]      rbusy,
  input  logic [NUM_WR-1:0]      reg_wr,
  input  logic [NUM_WR*AW-1:0]   waddr,
  input  logic [NUM_WR*XLEN-1:0] wdata,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_addr,
  output logic [AW:0]            busy_cnt
);

  localparam rst_mode_e RST_MODE = (RESET_TO_INDEX != 0) ? RST_INDEX : RST_ZERO;

  logic [XLEN-1:0]   regs_q [DEPTH];
  logic [XLEN-1:0]   regs_d [DEPTH];
  logic [MAX_WR-1:0] whit_s [DEPTH];
  logic [DEPTH-1:0]  wclr_s;
  logic [DEPTH-1:0]  busy_s;

  // Per-register write-port hits; register 0 never accepts a write
  always_comb begin
    wclr_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      whit_s[i] = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        whit_s[i][w] = reg_wr[w] && (waddr[w*AW +: AW] == AW'(i)) && (i != 0);
      end
      wclr_s[i] = |whit_s[i];
    end
  end

  // Next register contents, highest write port wins on collision
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wclr_s[i]) begin
        regs_d[i] = wdata[wr_prio_sel(whit_s[i])*XLEN +: XLEN];
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register array; reset checked first so a write in the reset cycle is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (RST_MODE == RST_INDEX) ? XLEN'(i) : '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .issue_en_i   (issue_en),
    .issue_addr_i (issue_addr),
    .clr_i        (wclr_s),
    .busy_o       (busy_s),
    .busy_cnt_o   (busy_cnt)
  );

  // Read ports
  always_comb begin
    logic [AW-1:0]     ra;
    logic [MAX_WR-1:0] rhit;
    ra    = '0;
    rhit  = '0;
    rdata = '0;
    rbusy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra   = raddr[p*AW +: AW];
      rhit = '0;
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        rhit[w] = reg_wr[w] && (waddr[w*AW +: AW] == ra) && (ra != '0);
      end
`endif
      if (|rhit) begin
        // Forwarded value is the one the write will commit; busy only if re-issued now
        rdata[p*XLEN +: XLEN] = wdata[wr_prio_sel(rhit)*XLEN +: XLEN];
        rbusy[p]              = issue_en && (issue_addr == ra);
      end else begin
        rdata[p*XLEN +: XLEN] = regs_q[ra];
        rbusy[p]              = busy_s[ra];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (NUM_WR=2, NUM_RD=2) plus a RESET_TO_INDEX=0 twin.
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_RD*AW-1:0]   raddr;
  logic [NUM_RD*XLEN-1:0] rdata;
  logic [NUM_RD-1:0]      rbusy;
  logic [NUM_WR-1:0]      reg_wr;
  logic [NUM_WR*AW-1:0]   waddr;
  logic [NUM_WR*XLEN-1:0] wdata;
  logic                   issue_en;
  logic [AW-1:0]          issue_addr;
  logic [AW:0]            busy_cnt;
  logic [NUM_RD*XLEN-1:0] rdata0;
  logic [NUM_RD-1:0]      rbusy0;
  logic [AW:0]            busy_cnt0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .RESET_TO_INDEX(1)) dut (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_cnt(busy_cnt)
  );

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .RESET_TO_INDEX(0)) dut0 (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata0), .rbusy(rbusy0),
    .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_cnt(busy_cnt0)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          step_no  = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_regs  [DEPTH];
  logic [31:0] m_regs0 [DEPTH];
  logic        m_busy  [DEPTH];
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i]  = 32'(i);
      m_regs0[i] = 32'h0;
      m_busy[i]  = 1'b0;
    end
    m_cnt = 0;
  endtask

  task automatic step(input logic rst, input logic [1:0] wr,
                      input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1,
                      input logic ie, input logic [4:0] ia,
                      input logic [4:0] ra0, input logic [4:0] ra1);
    logic [4:0]  ra;
    logic [31:0] ed;
    logic [31:0] ed0;
    logic        eb;
    logic [31:0] obs [6];
    step_no++;
    reset      = rst;
    reg_wr     = wr;
    waddr      = {wa1, wa0};
    wdata      = {wd1, wd0};
    issue_en   = ie;
    issue_addr = ia;
    raddr      = {ra1, ra0};
    for (int p = 0; p < NUM_RD; p++) begin
      ra  = (p == 0) ? ra0 : ra1;
      ed  = m_regs[ra];
      ed0 = m_regs0[ra];
      eb  = m_busy[ra];
`ifdef REGFILE_BYPASS_EN
      if (ra != 5'd0 && wr[0] && wa0 == ra) begin
        ed = wd0; ed0 = wd0; eb = ie && (ia == ra);
      end
      if (ra != 5'd0 && wr[1] && wa1 == ra) begin
        ed = wd1; ed0 = wd1; eb = ie && (ia == ra);
      end
`endif
      push_exp($sformatf("s%0d_rdata%0d", step_no, p), ed);
      push_exp($sformatf("s%0d_rbusy%0d", step_no, p), {31'd0, eb});
      if (p == 0) begin
        push_exp($sformatf("s%0d_busy_cnt", step_no), 32'(m_cnt));
        push_exp($sformatf("s%0d_zero_rst_rdata0", step_no), ed0);
      end
    end
    @(negedge clk);
    obs[0] = rdata[31:0];
    obs[1] = {31'd0, rbusy[0]};
    obs[2] = {26'd0, busy_cnt};
    obs[3] = rdata0[31:0];
    obs[4] = rdata[63:32];
    obs[5] = {31'd0, rbusy[1]};
    for (int i = 0; i < 6; i++) begin
      check_eq(tag_q.pop_front(), obs[i], exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (wr[0] && wa0 != 5'd0) begin
        m_regs[wa0] = wd0; m_regs0[wa0] = wd0; m_busy[wa0] = 1'b0;
      end
      if (wr[1] && wa1 != 5'd0) begin
        m_regs[wa1] = wd1; m_regs0[wa1] = wd1; m_busy[wa1] = 1'b0;
      end
      if (ie && ia != 5'd0) begin
        m_busy[ia] = 1'b1;
      end
      m_cnt = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_cnt += int'(m_busy[i]);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    reg_wr     = '0;
    waddr      = '0;
    wdata      = '0;
    issue_en   = 1'b0;
    issue_addr = '0;
    raddr      = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    //   rst  wr     wa0    wd0            wa1    wd1           ie    ia     ra0    ra1
    step(1'b1, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd0);
    step(1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd0);
    step(1'b0, 2'b01, 5'd3,  32'hDEADBEEF, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd4);
    step(1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd2);
    step(1'b0, 2'b01, 5'd0,  32'h1234,     5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd1);
    step(1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd3);
    step(1'b0, 2'b11, 5'd7,  32'h11,       5'd7,  32'h22,       1'b0, 5'd0,  5'd7,  5'd6);
    step(1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7);
    step(1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd8);
    step(1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd0);
    step(1'b0, 2'b10, 5'd0,  32'h0,        5'd9,  32'h99,       1'b0, 5'd0,  5'd9,  5'd9);
    step(1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd1);
    step(1'b0, 2'b01, 5'd9,  32'h55,       5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd3);
    step(1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9);
    step(1'b0, 2'b01, 5'd4,  32'hA5,       5'd0,  32'h0,        1'b0, 5'd0,  5'd4,  5'd4);
    step(1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd0,  5'd4,  5'd0);
    step(1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd12, 5'd0,  5'd12);
    step(1'b1, 2'b11, 5'd6,  32'hFF,       5'd3,  32'hEE,       1'b1, 5'd10, 5'd6,  5'd10);
    step(1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd6,  5'd10);
    step(1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd9);
    for (int k = 0; k < 60; k++) begin
      step(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 7)), $urandom(), 5'($urandom_range(0, 7)), $urandom(),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
